// File: rtl/ddr3_frame_arbiter_if.sv
// ddr3_frame_arbiter_if: DDR3 user command port handshake between arbiter (master) and controller (slave).
interface ddr3_frame_arbiter_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [27:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        burst_done;
    modport master (output cmd_valid, cmd_we, cmd_addr, cmd_len, input cmd_ready, burst_done);
    modport slave  (input cmd_valid, cmd_we, cmd_addr, cmd_len, output cmd_ready, burst_done);
endinterface

// File: rtl/ddr3_frame_arbiter.sv
// ddr3_frame_arbiter: burst-level arbitration of camera writes and LCD reads on one DDR3 command
// port, with burst address generation and ping-pong frame banks.
module ddr3_frame_arbiter #(
    parameter int BURST_LEN  = 64,
    parameter int ADDR_STEP  = 8,
    parameter int FIFO_DEPTH = 512,
    parameter int LOW_WM     = 128,
    parameter int CNT_W      = 10,
    parameter int BANK_SHIFT = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_done_i,
    input  logic [27:0]          ddr3_addr_max_i,
    input  logic                 wr_frame_start_i,
    input  logic                 rd_frame_start_i,
    input  logic [CNT_W-1:0]     wr_fifo_cnt_i,
    input  logic [CNT_W-1:0]     rd_fifo_cnt_i,
    ddr3_frame_arbiter_if.master cmd_if,
    output logic                 wr_bank_o,
    output logic                 rd_bank_o,
    output logic                 rd_enable_o
);
    localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, CMD = 2'd2, WAIT = 2'd3;
    localparam logic [CNT_W-1:0] WR_TH  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] RD_TH  = CNT_W'(FIFO_DEPTH - BURST_LEN);
    localparam logic [CNT_W-1:0] URG_TH = CNT_W'(LOW_WM);
    localparam logic [28:0]      STEP   = 29'(BURST_LEN * ADDR_STEP);

    logic [1:0]  state_q, state_d;
    logic        gnt_wr_q, gnt_wr_d, last_wr_q;
    logic        cmd_valid_q, cmd_we_q;
    logic [27:0] cmd_addr_q, wr_off_q, rd_off_q, off_d;
    logic [28:0] off_sum;
    logic        wr_bank_q, rd_bank_q, done_bank_q, rd_enable_q, wr_pend_q, rd_pend_q;
    logic        wr_req, rd_req, urgent, idle, hs, wr_go, rd_go;

    always_comb begin
        wr_req   = init_done_i & (wr_fifo_cnt_i >= WR_TH);
        rd_req   = init_done_i & rd_enable_q & (rd_fifo_cnt_i <= RD_TH);
        urgent   = rd_req & (rd_fifo_cnt_i < URG_TH);
        gnt_wr_d = urgent ? 1'b0 : (wr_req & rd_req) ? ~last_wr_q : wr_req;
        idle     = state_q == IDLE;
        hs       = (state_q == CMD) & cmd_if.cmd_ready;
        wr_go    = idle & (wr_frame_start_i | wr_pend_q);
        rd_go    = idle & (rd_frame_start_i | rd_pend_q);
        off_sum  = {1'b0, cmd_we_q ? wr_off_q : rd_off_q} + STEP;
        off_d    = (off_sum >= {1'b0, ddr3_addr_max_i}) ? 28'd0 : off_sum[27:0];
        state_d  = idle ? ((wr_req | rd_req) ? GRANT : IDLE) :
                   (state_q == GRANT) ? CMD :
                   hs ? WAIT :
                   ((state_q == WAIT) & cmd_if.burst_done) ? IDLE : state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_wr_q    <= 1'b0;
            last_wr_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            wr_off_q    <= '0;
            rd_off_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            done_bank_q <= 1'b0;
            rd_enable_q <= 1'b0;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_pend_q <= ~idle & (wr_pend_q | wr_frame_start_i);
            rd_pend_q <= ~idle & (rd_pend_q | rd_frame_start_i);
            if (idle) gnt_wr_q <= gnt_wr_d;
            if (state_q == GRANT) begin
                cmd_valid_q <= 1'b1;
                cmd_we_q    <= gnt_wr_q;
                last_wr_q   <= gnt_wr_q;
                cmd_addr_q  <= gnt_wr_q ? (({27'd0, wr_bank_q} << BANK_SHIFT) | wr_off_q)
                                        : (({27'd0, rd_bank_q} << BANK_SHIFT) | rd_off_q);
            end
            if (hs) begin
                cmd_valid_q <= 1'b0;
                if (cmd_we_q) wr_off_q <= off_d;
                else rd_off_q <= off_d;
            end
            // start events only land in IDLE so an in-flight burst keeps its bank/offset
            if (wr_go) begin
                wr_off_q    <= '0;
                wr_bank_q   <= ~wr_bank_q;
                done_bank_q <= wr_bank_q;
                rd_enable_q <= 1'b1;
            end
            if (rd_go) begin
                rd_off_q  <= '0;
                rd_bank_q <= wr_go ? wr_bank_q : done_bank_q;
            end
        end
    end

    assign cmd_if.cmd_valid = cmd_valid_q;
    assign cmd_if.cmd_we    = cmd_we_q;
    assign cmd_if.cmd_addr  = cmd_addr_q;
    assign cmd_if.cmd_len   = 8'(BURST_LEN - 1);
    assign wr_bank_o        = wr_bank_q;
    assign rd_bank_o        = rd_bank_q;
    assign rd_enable_o      = rd_enable_q;
endmodule
